// File: rtl/branch_cond_if.sv
// Branch request / branch result handshake bundle for branch_cond.
//
// Purpose: groups the two valid/ready channels between the fetch redirect
// logic (master) and the branch condition resolver (slave).
//
// Signals:
//   br_valid / br_ready   : branch request handshake (master -> slave)
//   br_cond               : 4-bit condition code
//   br_pc / br_target     : branch PC and taken target
//   res_valid / res_ready : result handshake (slave -> master)
//   res_taken             : branch resolved taken
//   res_illegal           : condition code 12..15 was presented
//   res_next_pc           : redirect PC (target or fall-through)
interface branch_cond_if #(
    parameter int ADDR_W = 64
);
    logic              br_valid;
    logic              br_ready;
    logic [3:0]        br_cond;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] br_target;
    logic              res_valid;
    logic              res_ready;
    logic              res_taken;
    logic              res_illegal;
    logic [ADDR_W-1:0] res_next_pc;

    modport master (
        output br_valid, br_cond, br_pc, br_target, res_ready,
        input  br_ready, res_valid, res_taken, res_illegal, res_next_pc
    );

    modport slave (
        input  br_valid, br_cond, br_pc, br_target, res_ready,
        output br_ready, res_valid, res_taken, res_illegal, res_next_pc
    );
endinterface

// File: rtl/branch_cond.sv
// Conditional branch resolver.
//
// Purpose: keeps the architectural {N,Z,SN} flags written by the ALU compare
// unit, counts CMPs whose flags have not yet returned, and resolves a branch
// against the flags once they are current. The result (taken, illegal, next
// PC) is returned over a valid/ready handshake.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   flush            : synchronous pipeline flush
//   flag_pend_set    : a CMP issued, its flags are outstanding
//   flag_valid       : CMP flags valid this cycle
//   flag_n/z/sn      : unsigned-less / equal / signed-less
//   bus              : branch request + result channels (slave side)
//   err_ovf          : sticky pending-counter overflow
module branch_cond #(
    parameter int ADDR_W      = 64,
    parameter int INSTR_BYTES = 8,
    parameter int PEND_W      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          flag_pend_set,
    input  logic          flag_valid,
    input  logic          flag_n,
    input  logic          flag_z,
    input  logic          flag_sn,
    branch_cond_if.slave  bus,
    output logic          err_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;

    state_t            state;
    state_t            state_next;

    logic              reg_n;
    logic              reg_z;
    logic              reg_sn;
    logic [PEND_W-1:0] pend;

    logic [3:0]        cap_cond;
    logic [ADDR_W-1:0] cap_pc;
    logic [ADDR_W-1:0] cap_target;

    logic              accept;
    logic              resolve_now;
    logic              resolve_wait;
    logic              load_result;
    logic [3:0]        sel_cond;
    logic [ADDR_W-1:0] sel_pc;
    logic [ADDR_W-1:0] sel_target;
    logic              eval_taken;
    logic              eval_illegal;
    logic [ADDR_W-1:0] eval_next_pc;
    logic              pend_inc;
    logic              pend_dec;

    // Condition table evaluated against the registered flags.
    function automatic logic cond_true(input logic [3:0] c, input logic n,
                                       input logic z, input logic sn);
        logic t;
        t = 1'b0;
        case (c)
            4'd0:    t = z;
            4'd1:    t = !z;
            4'd2:    t = n;
            4'd3:    t = !n;
            4'd4:    t = sn;
            4'd5:    t = !sn;
            4'd6:    t = n | z;
            4'd7:    t = !n & !z;
            4'd8:    t = sn | z;
            4'd9:    t = !sn & !z;
            4'd10:   t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // AL, NV and the illegal codes do not look at the flags, so they never
    // have to wait for outstanding CMPs.
    function automatic logic cond_flag_free(input logic [3:0] c);
        return c >= 4'd10;
    endfunction

    // Handshake and resolve qualifiers. Flush blocks both acceptance and
    // resolution so a flushed branch can never produce a result.
    always_comb begin
        accept       = bus.br_valid && (state == ST_IDLE) && !flush;
        resolve_now  = accept && (cond_flag_free(bus.br_cond) || (pend == PEND_ZERO));
        resolve_wait = (state == ST_WAIT) && (pend == PEND_ZERO) && !flush;
        load_result  = resolve_now || resolve_wait;
    end

    // In IDLE the branch is evaluated straight off the bus on the accept
    // edge; in WAIT the captured copy is used.
    always_comb begin
        if (state == ST_IDLE) begin
            sel_cond   = bus.br_cond;
            sel_pc     = bus.br_pc;
            sel_target = bus.br_target;
        end else begin
            sel_cond   = cap_cond;
            sel_pc     = cap_pc;
            sel_target = cap_target;
        end
        eval_illegal = sel_cond >= 4'd12;
        eval_taken   = cond_true(sel_cond, reg_n, reg_z, reg_sn);
        // Fall-through wraps modulo 2^ADDR_W by truncation.
        eval_next_pc = eval_taken ? sel_target
                                  : sel_pc + ADDR_W'(INSTR_BYTES);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_next = resolve_now ? ST_OUT : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (resolve_wait) begin
                        state_next = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.res_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        bus.br_ready  = (state == ST_IDLE);
        bus.res_valid = (state == ST_OUT);
    end

    // Flags register: every returning CMP result is architectural, even one
    // that arrives with nothing pending or during a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_n  <= 1'b0;
            reg_z  <= 1'b0;
            reg_sn <= 1'b0;
        end else if (flag_valid) begin
            reg_n  <= flag_n;
            reg_z  <= flag_z;
            reg_sn <= flag_sn;
        end
    end

    // A simultaneous issue and return cancel out; a return with nothing
    // pending is not counted.
    always_comb begin
        pend_inc = flag_pend_set;
        pend_dec = flag_valid && (pend != PEND_ZERO);
    end

    // Pending counter with sticky overflow. Flush clears the count but
    // leaves the overflow flag for post-mortem.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            err_ovf <= 1'b0;
        end else if (flush) begin
            pend    <= '0;
        end else if (pend_inc && !pend_dec) begin
            if (pend == PEND_MAX) begin
                err_ovf <= 1'b1;
            end else begin
                pend <= pend + 1'b1;
            end
        end else if (pend_dec && !pend_inc) begin
            pend <= pend - 1'b1;
        end
    end

    // Branch capture on accept and result registration on resolve. Results
    // hold while the state sits in OUT so back-pressure sees stable outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_cond        <= '0;
            cap_pc          <= '0;
            cap_target      <= '0;
            bus.res_taken   <= 1'b0;
            bus.res_illegal <= 1'b0;
            bus.res_next_pc <= '0;
        end else begin
            if (accept) begin
                cap_cond   <= bus.br_cond;
                cap_pc     <= bus.br_pc;
                cap_target <= bus.br_target;
            end
            if (load_result) begin
                bus.res_taken   <= eval_taken;
                bus.res_illegal <= eval_illegal;
                bus.res_next_pc <= eval_next_pc;
            end
        end
    end

endmodule

// File: tb/tb_branch_cond.sv
// Self-checking bench for branch_cond.
//
// Purpose: drives flag traffic and branch requests, pushes the expected
// result of each branch onto a scoreboard queue when it is issued, and pops
// and compares when the DUT presents a result.
module tb_branch_cond;

    typedef struct packed {
        logic        taken;
        logic        illegal;
        logic [63:0] next_pc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;
    logic flag_pend_set;
    logic flag_valid;
    logic flag_n;
    logic flag_z;
    logic flag_sn;
    logic err_ovf;

    int   total;
    int   bad;
    exp_t sb[$];

    logic mf_n;
    logic mf_z;
    logic mf_sn;

    branch_cond_if #(.ADDR_W(64)) bif ();

    branch_cond #(
        .ADDR_W(64),
        .INSTR_BYTES(8),
        .PEND_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .flag_pend_set(flag_pend_set),
        .flag_valid(flag_valid),
        .flag_n(flag_n),
        .flag_z(flag_z),
        .flag_sn(flag_sn),
        .bus(bif),
        .err_ovf(err_ovf)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table written from the condition-code list.
    function automatic exp_t model(input logic [3:0] c, input logic n,
                                   input logic z, input logic sn,
                                   input logic [63:0] pc, input logic [63:0] tgt);
        exp_t e;
        logic t;
        logic il;
        il = 1'b0;
        case (c)
            4'd0:    t = z;
            4'd1:    t = ~z;
            4'd2:    t = n;
            4'd3:    t = ~n;
            4'd4:    t = sn;
            4'd5:    t = ~sn;
            4'd6:    t = n | z;
            4'd7:    t = ~(n | z);
            4'd8:    t = sn | z;
            4'd9:    t = ~(sn | z);
            4'd10:   t = 1'b1;
            4'd11:   t = 1'b0;
            default: begin t = 1'b0; il = 1'b1; end
        endcase
        e.taken   = t;
        e.illegal = il;
        e.next_pc = t ? tgt : pc + 64'd8;
        return e;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle CMP result, mirrored into the model flags.
    task automatic load_flags(input logic n, input logic z, input logic sn);
        flag_valid = 1'b1;
        flag_n     = n;
        flag_z     = z;
        flag_sn    = sn;
        mf_n       = n;
        mf_z       = z;
        mf_sn      = sn;
        tick();
        flag_valid = 1'b0;
    endtask

    task automatic pend_pulse();
        flag_pend_set = 1'b1;
        tick();
        flag_pend_set = 1'b0;
    endtask

    // Present a branch for one cycle while the DUT is in IDLE.
    task automatic send_branch(input logic [3:0] c, input logic [63:0] pc,
                               input logic [63:0] tgt);
        bif.br_valid  = 1'b1;
        bif.br_cond   = c;
        bif.br_pc     = pc;
        bif.br_target = tgt;
        tick();
        bif.br_valid  = 1'b0;
    endtask

    // Bounded wait for res_valid; cyc reports the edges waited.
    task automatic wait_res(output int cyc);
        cyc = 0;
        while (bif.res_valid !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        total++;
        if (bif.br_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_br_ready got=%b want=1", bif.br_ready);
        end
        total++;
        if (bif.res_valid !== 1'b0 || bif.res_taken !== 1'b0 || bif.res_illegal !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_res got v=%b t=%b i=%b want 0 0 0",
                            bif.res_valid, bif.res_taken, bif.res_illegal);
        end
        total++;
        if (bif.res_next_pc !== 64'd0 || err_ovf !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_pc_ovf got pc=%h ovf=%b want 0 0",
                            bif.res_next_pc, err_ovf);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   cyc;
        logic [3:0]  cs [3] = '{4'd0, 4'd2, 4'd4};
        logic [63:0] ps [3] = '{64'h100, 64'h200, 64'h300};
        logic [63:0] ts [3] = '{64'h800, 64'h900, 64'hA00};
        load_flags(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            // After EQ, switch to N=1,SN=0 so LTU takes and LT falls through.
            if (k == 1) load_flags(1'b1, 1'b0, 1'b0);
            sb.push_back(model(cs[k], mf_n, mf_z, mf_sn, ps[k], ts[k]));
            send_branch(cs[k], ps[k], ts[k]);
            wait_res(cyc);
            e = sb.pop_front();
            total++;
            if (cyc != 0) begin
                bad++; $display("[TB] FAIL basic_latency cond=%0d got=%0d want=0", cs[k], cyc);
            end
            total++;
            if (bif.res_valid !== 1'b1 || bif.res_taken !== e.taken ||
                bif.res_illegal !== e.illegal || bif.res_next_pc !== e.next_pc) begin
                bad++; $display("[TB] FAIL basic_result cond=%0d got t=%b i=%b pc=%h want t=%b i=%b pc=%h",
                                cs[k], bif.res_taken, bif.res_illegal, bif.res_next_pc,
                                e.taken, e.illegal, e.next_pc);
            end
            tick();
        end
    endtask

    task automatic test_sweep();
        exp_t        e;
        int          cyc;
        logic [63:0] pc;
        logic [63:0] tgt;
        for (int f = 0; f < 8; f++) begin
            load_flags(f[2], f[1], f[0]);
            for (int c = 0; c < 16; c++) begin
                pc  = {$urandom, $urandom} & ~64'h7;
                tgt = {$urandom, $urandom};
                sb.push_back(model(4'(c), mf_n, mf_z, mf_sn, pc, tgt));
                send_branch(4'(c), pc, tgt);
                wait_res(cyc);
                e = sb.pop_front();
                total++;
                if (bif.res_valid !== 1'b1 || bif.res_taken !== e.taken ||
                    bif.res_illegal !== e.illegal || bif.res_next_pc !== e.next_pc) begin
                    bad++; $display("[TB] FAIL sweep nzs=%0d cond=%0d got v=%b t=%b i=%b pc=%h want t=%b i=%b pc=%h",
                                    f, c, bif.res_valid, bif.res_taken, bif.res_illegal,
                                    bif.res_next_pc, e.taken, e.illegal, e.next_pc);
                end
                tick();
            end
        end
    endtask

    task automatic test_pending_wait();
        exp_t e;
        int   cyc;
        // Stale flags would make GT not taken.
        load_flags(1'b0, 1'b1, 1'b0);
        pend_pulse();
        sb.push_back(model(4'd9, 1'b1, 1'b0, 1'b0, 64'h1200, 64'h2000));
        send_branch(4'd9, 64'h1200, 64'h2000);
        total++;
        if (bif.br_ready !== 1'b0 || bif.res_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL pend_wait_state got rdy=%b v=%b want 0 0",
                            bif.br_ready, bif.res_valid);
        end
        tick();
        load_flags(1'b1, 1'b0, 1'b0);
        total++;
        if (bif.res_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL pend_early got v=%b want 0", bif.res_valid);
        end
        wait_res(cyc);
        e = sb.pop_front();
        total++;
        if (cyc != 1) begin
            bad++; $display("[TB] FAIL pend_latency got=%0d want=1", cyc);
        end
        total++;
        if (bif.res_taken !== e.taken || bif.res_next_pc !== e.next_pc) begin
            bad++; $display("[TB] FAIL pend_result got t=%b pc=%h want t=%b pc=%h",
                            bif.res_taken, bif.res_next_pc, e.taken, e.next_pc);
        end
        tick();
    endtask

    task automatic test_flag_independent();
        exp_t        e;
        int          cyc;
        logic [3:0]  cs [2] = '{4'd10, 4'd13};
        logic [63:0] ps [2] = '{64'h300, 64'h308};
        logic [63:0] ts [2] = '{64'h40, 64'h999};
        pend_pulse();
        for (int k = 0; k < 2; k++) begin
            sb.push_back(model(cs[k], mf_n, mf_z, mf_sn, ps[k], ts[k]));
            send_branch(cs[k], ps[k], ts[k]);
            wait_res(cyc);
            e = sb.pop_front();
            total++;
            if (cyc != 0 || bif.res_taken !== e.taken || bif.res_illegal !== e.illegal ||
                bif.res_next_pc !== e.next_pc) begin
                bad++; $display("[TB] FAIL indep cond=%0d got cyc=%0d t=%b i=%b pc=%h want cyc=0 t=%b i=%b pc=%h",
                                cs[k], cyc, bif.res_taken, bif.res_illegal, bif.res_next_pc,
                                e.taken, e.illegal, e.next_pc);
            end
            tick();
        end
        load_flags(mf_n, mf_z, mf_sn);
        total++;
        if (dut.pend !== 3'd0) begin
            bad++; $display("[TB] FAIL indep_drain got pend=%0d want=0", dut.pend);
        end
    endtask

    task automatic test_wrap_backpressure();
        exp_t        e;
        int          cyc;
        logic [63:0] snap_pc;
        logic        snap_t;
        logic        snap_i;
        bif.res_ready = 1'b0;
        sb.push_back(model(4'd11, mf_n, mf_z, mf_sn, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1234));
        send_branch(4'd11, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1234);
        wait_res(cyc);
        e = sb.pop_front();
        total++;
        if (bif.res_valid !== 1'b1 || bif.res_next_pc !== e.next_pc || bif.res_taken !== e.taken) begin
            bad++; $display("[TB] FAIL wrap got v=%b t=%b pc=%h want v=1 t=%b pc=%h",
                            bif.res_valid, bif.res_taken, bif.res_next_pc, e.taken, e.next_pc);
        end
        snap_pc = bif.res_next_pc;
        snap_t  = bif.res_taken;
        snap_i  = bif.res_illegal;
        // A competing request must not be accepted while the result waits.
        bif.br_valid = 1'b1;
        bif.br_cond  = 4'd10;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (bif.res_valid !== 1'b1 || bif.br_ready !== 1'b0 || bif.res_next_pc !== snap_pc ||
                bif.res_taken !== snap_t || bif.res_illegal !== snap_i) begin
                bad++; $display("[TB] FAIL backpressure cyc=%0d got v=%b rdy=%b pc=%h want v=1 rdy=0 pc=%h",
                                k, bif.res_valid, bif.br_ready, bif.res_next_pc, snap_pc);
            end
        end
        bif.br_valid  = 1'b0;
        bif.res_ready = 1'b1;
        tick();
        total++;
        if (bif.res_valid !== 1'b0 || bif.br_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL bp_release got v=%b rdy=%b want 0 1",
                            bif.res_valid, bif.br_ready);
        end
    endtask

    task automatic test_overflow_flush();
        exp_t e;
        int   cyc;
        flag_pend_set = 1'b1;
        repeat (7) tick();
        total++;
        if (dut.pend !== 3'd7 || err_ovf !== 1'b0) begin
            bad++; $display("[TB] FAIL ovf_pre got pend=%0d ovf=%b want 7 0", dut.pend, err_ovf);
        end
        tick();
        flag_pend_set = 1'b0;
        total++;
        if (dut.pend !== 3'd7 || err_ovf !== 1'b1) begin
            bad++; $display("[TB] FAIL ovf_sat got pend=%0d ovf=%b want 7 1", dut.pend, err_ovf);
        end
        // This branch is flushed, so nothing goes on the scoreboard.
        send_branch(4'd0, 64'h500, 64'h600);
        tick();
        total++;
        if (bif.br_ready !== 1'b0 || bif.res_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL flush_pre got rdy=%b v=%b want 0 0", bif.br_ready, bif.res_valid);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (bif.br_ready !== 1'b1 || bif.res_valid !== 1'b0 || dut.pend !== 3'd0 || err_ovf !== 1'b1) begin
            bad++; $display("[TB] FAIL flush got rdy=%b v=%b pend=%0d ovf=%b want 1 0 0 1",
                            bif.br_ready, bif.res_valid, dut.pend, err_ovf);
        end
        // Flags survive the flush; EQ resolves at once since pend cleared.
        sb.push_back(model(4'd0, mf_n, mf_z, mf_sn, 64'h700, 64'h780));
        send_branch(4'd0, 64'h700, 64'h780);
        wait_res(cyc);
        e = sb.pop_front();
        total++;
        if (cyc != 0 || bif.res_taken !== e.taken || bif.res_next_pc !== e.next_pc) begin
            bad++; $display("[TB] FAIL post_flush got cyc=%0d t=%b pc=%h want cyc=0 t=%b pc=%h",
                            cyc, bif.res_taken, bif.res_next_pc, e.taken, e.next_pc);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int cyc;
        load_flags(1'b1, 1'b1, 1'b1);
        pend_pulse();
        bif.res_ready = 1'b0;
        send_branch(4'd10, 64'hA00, 64'hBEEF0);
        wait_res(cyc);
        total++;
        if (bif.res_valid !== 1'b1 || bif.res_next_pc !== 64'hBEEF0) begin
            bad++; $display("[TB] FAIL arst_setup got v=%b pc=%h want 1 beef0", bif.res_valid, bif.res_next_pc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bif.res_valid !== 1'b0 || bif.br_ready !== 1'b1 || bif.res_taken !== 1'b0 ||
            bif.res_next_pc !== 64'd0 || err_ovf !== 1'b0) begin
            bad++; $display("[TB] FAIL arst_outputs got v=%b rdy=%b t=%b pc=%h ovf=%b want 0 1 0 0 0",
                            bif.res_valid, bif.br_ready, bif.res_taken, bif.res_next_pc, err_ovf);
        end
        total++;
        if (dut.pend !== 3'd0 || {dut.reg_n, dut.reg_z, dut.reg_sn} !== 3'b000) begin
            bad++; $display("[TB] FAIL arst_state got pend=%0d flags=%b want 0 000",
                            dut.pend, {dut.reg_n, dut.reg_z, dut.reg_sn});
        end
        #3;
        rst_n = 1'b1;
        bif.res_ready = 1'b1;
        mf_n = 1'b0; mf_z = 1'b0; mf_sn = 1'b0;
        tick();
    endtask

    // Test sequence.
    initial begin
        total = 0;
        bad   = 0;
        mf_n  = 1'b0; mf_z = 1'b0; mf_sn = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        flag_pend_set = 1'b0;
        flag_valid = 1'b0;
        flag_n = 1'b0; flag_z = 1'b0; flag_sn = 1'b0;
        bif.br_valid  = 1'b0;
        bif.br_cond   = 4'd0;
        bif.br_pc     = 64'd0;
        bif.br_target = 64'd0;
        bif.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        test_reset();
        test_basic();
        test_sweep();
        test_pending_wait();
        test_flag_independent();
        test_wrap_backpressure();
        test_overflow_flush();
        test_async_reset();

        total++;
        if (sb.size() != 0) begin
            bad++; $display("[TB] FAIL scoreboard_empty got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_cond.md
# branch_cond

Consumes the `n`/`z`/`sn` flags produced by the ALU compare unit and resolves conditional branches against them. It holds the architectural flags register, tracks outstanding CMP results with a pending counter, and stalls a branch until its flags are current. It sits between the ALU result path and the fetch redirect logic, and returns taken/not-taken plus the next PC through a valid/ready handshake.

## Interface
- `ADDR_W`, 64: PC / target width.
- `INSTR_BYTES`, 8: fall-through increment.
- `PEND_W`, 3: pending-CMP counter width (max outstanding = 2^PEND_W−1).

- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: synchronous pipeline flush.
- `flag_pend_set` in 1: a CMP has issued; its flags are outstanding.
- `flag_valid` in 1: CMP result valid this cycle.
- `flag_n`, `flag_z`, `flag_sn` in 1 each: unsigned-less, equal, signed-less.
- `br_valid` in 1 / `br_ready` out 1: branch request handshake.
- `br_cond` in 4: condition code.
- `br_pc`, `br_target` in ADDR_W: branch PC and taken target.
- `res_valid` out 1 / `res_ready` in 1: result handshake.
- `res_taken` out 1, `res_illegal` out 1, `res_next_pc` out ADDR_W.
- `err_ovf` out 1: sticky pending-counter overflow.

## Operation
- Flags register `{N,Z,SN}` loads from `flag_*` on every `flag_valid`, whether or not anything is pending.
- Pending count `pend`:
  - +1 on `flag_pend_set`.
  - −1 on `flag_valid` when `pend`≠0.
  - Both in one cycle: unchanged.
  - `flag_valid` with `pend`=0: flags load, count stays 0.
  - `flag_pend_set` at max count (no `flag_valid`): count holds and `err_ovf` sets; it clears only on reset.
- Condition codes, evaluated on the registered flags:
  - 0 EQ `Z`; 1 NE `!Z`
  - 2 LTU `N`; 3 GEU `!N`
  - 4 LT `SN`; 5 GE `!SN`
  - 6 LEU `N|Z`; 7 GTU `!N&!Z`
  - 8 LE `SN|Z`; 9 GT `!SN&!Z`
  - 10 AL `1`; 11 NV `0`
  - 12–15 illegal: `res_taken`=0 and `res_illegal`=1.
- Flag-independent codes are AL, NV and 12–15. They never wait on `pend`.
- `res_next_pc` = `res_taken` ? `br_target` : `br_pc`+`INSTR_BYTES`. The sum is modulo 2^ADDR_W, so fall-through wraps.
- State machine:
  - IDLE: `br_ready`=1. On accept, the branch's pc, target and cond are captured.
    - If the code is flag-independent or `pend`=0, the result is registered on the accept edge and the state goes to OUT.
    - Otherwise the state goes to WAIT.
  - WAIT: `br_ready`=0. Each cycle, if `pend`=0 (registered value), evaluate, register the result, and go to OUT.
  - OUT: `res_valid`=1. Outputs are stable until `res_valid&&res_ready`, then the state returns to IDLE. No new branch is accepted in OUT.
- `flush` has priority over all other activity:
  - State goes to IDLE and `res_valid` drops.
  - The captured branch is discarded and `pend` clears to 0.
  - The flags register and `err_ovf` are preserved.

## Timing
- Reset values:
  - State IDLE, `pend`=0, flags 000.
  - `br_ready`=1.
  - `res_valid`=0, `res_taken`=0, `res_illegal`=0, `res_next_pc`=0.
  - `err_ovf`=0.
- Latency with no pending flags: branch accepted at edge T, `res_valid` high in the cycle after T.
- With pending flags: the final `flag_valid` is sampled at edge F and evaluation happens at F+1. `res_valid` is high after F+1, i.e. 2 cycles after the flags arrive.
- `flag_valid` and branch acceptance in the same cycle with `pend`=1: the branch goes to WAIT and resolves one cycle later on the new flags. There is no bypass.
- Throughput: at most one branch per 2 cycles (IDLE→OUT→IDLE) with `res_ready` held high.
- Back-pressure: with `res_ready`=0, OUT holds indefinitely and all `res_*` outputs are stable.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously.

## Test plan
- Flags N=0,Z=1,SN=0; branch cond EQ, pc=0x100, target=0x800 → next cycle `res_valid`=1, `res_taken`=1, `res_next_pc`=0x800.
- Flags N=1,SN=0 (e.g. CMP 1 vs −1): LTU → taken, LT → not taken with `res_next_pc`=pc+8. Sweep all 16 codes over all 8 flag combinations against the condition table.
- `flag_pend_set` pulse, then a GT branch, then `flag_valid` with Z=0,SN=0 two cycles later → branch stays in WAIT with `br_ready`=0; `res_valid` rises 2 cycles after `flag_valid` with `res_taken`=1.
- Pending count 1; AL branch with target 0x40 → resolves without waiting, `res_next_pc`=0x40. Code 13 → `res_illegal`=1, `res_taken`=0.
- `br_pc`=0xFFFF_FFFF_FFFF_FFF8, NV → `res_next_pc`=0. With `res_ready` low for 5 cycles, `res_*` are stable and `br_ready`=0.
- Eight `flag_pend_set` pulses from pend=0 → `err_ovf`=1 and pend saturates at 7. `flush` during WAIT → next cycle IDLE, `pend`=0, `res_valid`=0, `err_ovf` still 1. Asserting `rst_n` low clears everything to reset values.
